// File: rtl/multi_clock_trigger.sv
`timescale 1ns/1ps
// multi_clock_trigger: per-channel triggered clock generator, gated (mode 0) or burst (mode 1).
// Optional macro CLKTRIG_DUTY_EN makes the high phase programmable through hi_cnt.
module multi_clock_trigger #(
  parameter int NCH   = 4,
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             fastclk,
  input  logic             reset,
  input  logic [NCH-1:0]   trigger,
  input  logic             mode,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] hi_cnt,
  input  logic [CNT_W-1:0] burst_len,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   done,
  output logic [2*NCH-1:0] state_dbg
);
  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2, DONE = 2'd3} state_t;

  localparam logic [DIV_W:0] ONE     = (DIV_W+1)'(1);
  localparam logic [DIV_W:0] TWO     = (DIV_W+1)'(2);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NCH-1:0] sync1, trig_s, trig_q;

  always_ff @(posedge fastclk or negedge reset) begin
    if (!reset) begin
      sync1  <= '0;
      trig_s <= '0;
      trig_q <= '0;
    end else begin
      sync1  <= trigger;
      trig_s <= sync1;
      trig_q <= trig_s;
    end
  end

`ifndef CLKTRIG_DUTY_EN
  logic unused_hi;
  assign unused_hi = ^hi_cnt;
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_t           state, state_nx;
    logic             mode_l;
    logic [DIV_W-1:0] div_l;
    logic [CNT_W-1:0] len_l, pulses;
    logic [DIV_W:0]   per, h_len, l_len, ph_cnt;
    logic             clk_r, busy_r, done_r;
`ifdef CLKTRIG_DUTY_EN
    logic [DIV_W-1:0] hi_l;
`endif

    // Phase lengths come only from values latched at the start of the current period.
    always_comb begin
      per = (div_l == '0) ? TWO : {1'b0, div_l} + ONE;
`ifdef CLKTRIG_DUTY_EN
      if (hi_l == '0)               h_len = ONE;
      else if ({1'b0, hi_l} >= per) h_len = per - ONE;
      else                          h_len = {1'b0, hi_l};
`else
      h_len = per >> 1;
`endif
      l_len = per - h_len;
    end

    always_comb begin
      state_nx = state;
      case (state)
        IDLE: begin
          if (mode && trig_s[c] && !trig_q[c])
            state_nx = (burst_len == '0) ? DONE : HIGH;
          else if (!mode && trig_s[c])
            state_nx = HIGH;
        end
        HIGH: if (ph_cnt == h_len - ONE) state_nx = LOW;
        LOW: begin
          if (ph_cnt == l_len - ONE) begin
            if (mode_l) state_nx = (pulses == len_l) ? DONE : HIGH;
            else        state_nx = trig_s[c] ? HIGH : IDLE;
          end
        end
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end

    always_ff @(posedge fastclk or negedge reset) begin
      if (!reset) begin
        state  <= IDLE;
        ph_cnt <= '0;
        pulses <= '0;
        mode_l <= 1'b0;
        div_l  <= '0;
        len_l  <= '0;
        clk_r  <= 1'b0;
        busy_r <= 1'b0;
        done_r <= 1'b0;
`ifdef CLKTRIG_DUTY_EN
        hi_l   <= '0;
`endif
      end else begin
        state  <= state_nx;
        ph_cnt <= (state_nx != state || state == IDLE) ? '0 : ph_cnt + ONE;
        // mode is tracked while idle only, so a busy channel keeps the mode it started with.
        if (state == IDLE) begin
          mode_l <= mode;
          pulses <= '0;
        end else if (state == HIGH && state_nx == LOW) begin
          pulses <= pulses + CNT_ONE;
        end
        if (state_nx == HIGH && state != HIGH) begin
          div_l <= div;
          len_l <= burst_len;
`ifdef CLKTRIG_DUTY_EN
          hi_l  <= hi_cnt;
`endif
        end
        clk_r  <= (state == HIGH);
        busy_r <= (state != IDLE);
        done_r <= (state == DONE);
      end
    end

    assign clk_out[c]          = clk_r;
    assign busy[c]             = busy_r;
    assign done[c]             = done_r;
    assign state_dbg[2*c +: 2] = state;
  end

endmodule

// File: tb/tb_multi_clock_trigger.sv
`timescale 1ns/1ps
// Bench for multi_clock_trigger: random gated/burst stimulus, per-channel event scoreboard
// fed by a period-level model; a monitor turns clk_out/busy/done into pulse/done/busy events.
module tb_multi_clock_trigger;
  localparam int NCH   = 4;
  localparam int DIV_W = 8;
  localparam int CNT_W = 8;
  localparam int EW    = 18;
`ifdef CLKTRIG_DUTY_EN
  localparam bit DUTY_EN = 1'b1;
`else
  localparam bit DUTY_EN = 1'b0;
`endif

  logic             fastclk = 1'b0;
  logic             reset = 1'b0;
  logic [NCH-1:0]   trigger = '0;
  logic             mode = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic [DIV_W-1:0] hi_cnt = '0;
  logic [CNT_W-1:0] burst_len = '0;
  logic [NCH-1:0]   clk_out, busy, done;
  logic [2*NCH-1:0] state_dbg;

  int   total = 0;
  int   bad = 0;
  logic mon_en = 1'b0;
  logic [EW-1:0] exp_q[NCH][$];

  // clock/reset block
  always #2 fastclk = ~fastclk;

  multi_clock_trigger #(.NCH(NCH), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .fastclk(fastclk), .reset(reset), .trigger(trigger), .mode(mode), .div(div),
    .hi_cnt(hi_cnt), .burst_len(burst_len), .clk_out(clk_out), .busy(busy),
    .done(done), .state_dbg(state_dbg)
  );

  // reference model: period length and phase split from the programmed values
  function automatic int p_of(int dv);
    return ((dv == 0) ? 1 : dv) + 1;
  endfunction

  function automatic int h_of(int dv, int hc);
    int p;
    p = p_of(dv);
    if (!DUTY_EN) return p / 2;
    if (hc < 1) return 1;
    if (hc > p - 1) return p - 1;
    return hc;
  endfunction

  function automatic logic [EW-1:0] ev_pulse(int h, int l);
    return {2'd0, h[7:0], l[7:0]};
  endfunction

  function automatic logic [EW-1:0] ev_done();
    return {2'd1, 16'd0};
  endfunction

  function automatic logic [EW-1:0] ev_busy(int n);
    return {2'd2, n[15:0]};
  endfunction

  // Gated: trigger held t cycles is seen on t consecutive FSM edges starting at period entry;
  // another period starts whenever a period ends inside that window.
  task automatic expect_gated(int c, int t, int dv0, int dv_rest, int hc);
    int k, p, h, sum;
    k = 0;
    sum = 0;
    do begin
      p = p_of((k == 0) ? dv0 : dv_rest);
      h = h_of((k == 0) ? dv0 : dv_rest, hc);
      exp_q[c].push_back(ev_pulse(h, p - h));
      sum += p;
      k++;
    end while (sum <= t - 1);
    exp_q[c].push_back(ev_busy(sum));
  endtask

  task automatic expect_burst(int c, int bl, int dv, int hc);
    int p, h;
    p = p_of(dv);
    h = h_of(dv, hc);
    for (int i = 0; i < bl; i++) exp_q[c].push_back(ev_pulse(h, p - h));
    exp_q[c].push_back(ev_done());
    exp_q[c].push_back(ev_busy(bl * p + 1));
  endtask

  // scoreboard
  task automatic check_ev(int c, logic [EW-1:0] got);
    logic [EW-1:0] want;
    total++;
    if (exp_q[c].size() == 0) begin
      bad++;
      $display("FAIL ch%0d event: got %h, required no event", c, got);
    end else begin
      want = exp_q[c].pop_front();
      if (got !== want) begin
        bad++;
        $display("FAIL ch%0d event: got %h required %h", c, got, want);
      end
    end
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  // monitor
  int phase[NCH], hcnt[NCH], lcnt[NCH], brun[NCH];

  always @(negedge fastclk) begin
    for (int c = 0; c < NCH; c++) begin
      if (!mon_en) begin
        phase[c] = 0; hcnt[c] = 0; lcnt[c] = 0; brun[c] = 0;
      end else begin
        if (clk_out[c]) begin
          if (phase[c] == 2) check_ev(c, ev_pulse(hcnt[c], lcnt[c]));
          if (phase[c] != 1) begin phase[c] = 1; hcnt[c] = 0; end
          hcnt[c]++;
        end else if (phase[c] == 1) begin
          phase[c] = 2;
          lcnt[c] = 1;
        end else if (phase[c] == 2) begin
          if (busy[c] && !done[c]) lcnt[c]++;
          else begin
            check_ev(c, ev_pulse(hcnt[c], lcnt[c]));
            phase[c] = 0;
          end
        end
        if (done[c]) check_ev(c, ev_done());
        if (busy[c]) brun[c]++;
        else if (brun[c] > 0) begin
          check_ev(c, ev_busy(brun[c]));
          brun[c] = 0;
        end
      end
    end
  end

  // driver tasks
  task automatic drive_trig(logic [NCH-1:0] mask, int t);
    @(negedge fastclk);
    trigger = trigger | mask;
    repeat (t) @(negedge fastclk);
    trigger = trigger & ~mask;
  endtask

  task automatic set_cfg(logic m, int dv, int hc, int bl);
    @(negedge fastclk);
    mode = m;
    div = DIV_W'(dv);
    hi_cnt = DIV_W'(hc);
    burst_len = CNT_W'(bl);
  endtask

  task automatic wait_idle(string tag);
    int n;
    n = 0;
    repeat (4) @(negedge fastclk);
    while (busy != '0 && n < 3000) begin
      @(negedge fastclk);
      n++;
    end
    total++;
    if (busy != '0) begin
      bad++;
      $display("FAIL %s idle timeout: busy=%b required 0", tag, busy);
    end
    repeat (3) @(negedge fastclk);
    for (int c = 0; c < NCH; c++) begin
      total++;
      if (exp_q[c].size() != 0) begin
        bad++;
        $display("FAIL %s ch%0d leftover: %0d events outstanding, required 0", tag, c, exp_q[c].size());
        exp_q[c].delete();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic m;
    int dv, hc, bl, t;
    logic [NCH-1:0] mask;

    repeat (3) @(negedge fastclk);
    chk("reset clk_out", 32'(clk_out), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset state", 32'(state_dbg), 0);
    reset = 1'b1;
    @(negedge fastclk);
    mon_en = 1'b1;

    // gated, div=3, 12-cycle trigger on channel 0
    set_cfg(1'b0, 3, 0, 0);
    expect_gated(0, 12, 3, 3, 0);
    drive_trig(4'b0001, 12);
    wait_idle("gated12");

    // burst of 5 on channel 1 with a retrigger mid-burst
    set_cfg(1'b1, 1, 0, 5);
    expect_burst(1, 5, 1, 0);
    drive_trig(4'b0010, 3);
    repeat (2) @(negedge fastclk);
    drive_trig(4'b0010, 3);
    wait_idle("burst5");

    // zero-length burst on channel 2
    set_cfg(1'b1, 2, 0, 0);
    expect_burst(2, 0, 2, 0);
    drive_trig(4'b0100, 3);
    wait_idle("burst0");

    // trigger dropped mid-HIGH still gives one full period
    set_cfg(1'b0, 3, 0, 0);
    expect_gated(2, 2, 3, 3, 0);
    drive_trig(4'b0100, 2);
    wait_idle("gated_drop");

    // div changed to 7 during the first HIGH
    set_cfg(1'b0, 3, 0, 0);
    expect_gated(3, 20, 3, 7, 0);
    fork
      drive_trig(4'b1000, 20);
      begin
        n = 0;
        @(negedge fastclk);
        while (!clk_out[3] && n < 100) begin
          @(negedge fastclk);
          n++;
        end
        chk("divchg first rise", 32'(clk_out[3]), 1);
        div = DIV_W'(7);
      end
    join
    wait_idle("div_change");

`ifdef CLKTRIG_DUTY_EN
    for (int i = 0; i < 3; i++) begin
      hc = (i == 0) ? 1 : (i == 1) ? 9 : 0;
      set_cfg(1'b1, 4, hc, 2);
      expect_burst(0, 2, 4, hc);
      drive_trig(4'b0001, 3);
      wait_idle("duty");
    end
`endif

    // randomized gated/burst on random channel sets (shared start -> aligned outputs)
    for (int it = 0; it < 24; it++) begin
      m    = 1'($urandom_range(0, 1));
      dv   = $urandom_range(0, 9);
      hc   = $urandom_range(0, 12);
      bl   = $urandom_range(0, 6);
      t    = $urandom_range(1, 25);
      mask = NCH'($urandom_range(1, 15));
      set_cfg(m, dv, hc, bl);
      for (int c = 0; c < NCH; c++) begin
        if (mask[c]) begin
          if (m) expect_burst(c, bl, dv, hc);
          else   expect_gated(c, t, dv, dv, hc);
        end
      end
      drive_trig(mask, m ? 3 : t);
      wait_idle("random");
    end

    // asynchronous reset in the middle of a HIGH phase on all channels
    mon_en = 1'b0;
    set_cfg(1'b1, 3, 0, 10);
    @(negedge fastclk);
    trigger = '1;
    n = 0;
    while (!clk_out[0] && n < 100) begin
      @(negedge fastclk);
      n++;
    end
    chk("pre-reset clk_out", 32'(clk_out), 32'hF);
    #1;
    reset = 1'b0;
    #0.5;
    chk("async reset clk_out", 32'(clk_out), 0);
    chk("async reset busy", 32'(busy), 0);
    chk("async reset done", 32'(done), 0);
    chk("async reset state", 32'(state_dbg), 0);
    trigger = '0;
    repeat (2) @(negedge fastclk);
    reset = 1'b1;
    repeat (2) @(negedge fastclk);
    mon_en = 1'b1;
    n = 0;
    repeat (30) begin
      @(negedge fastclk);
      if (clk_out != '0 || busy != '0) n++;
    end
    chk("post-reset quiet cycles", 32'(n), 0);
    wait_idle("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
